frac_cen_gen: RTL and testbench

//  Multi-channel fractional clock-enable generator on the 72 MHz PLL output clock.

---
 rtl/frac_cen_pkg.sv | 42 ++++
 rtl/frac_cen_ch.sv | 58 +++++
 rtl/frac_cen_gen.sv | 93 +++++++++
 tb/tb_frac_cen_gen.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_cen_pkg.sv
// Shared types and the per-channel accumulator step for the fractional clock-enable generator.
package frac_cen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } lock_state_e;

    // Widest ratio supported by frac_step; two spare bits cover the sum and the accumulator headroom.
    localparam int unsigned FRAC_W_MAX = 32;
    localparam int unsigned STEP_W     = FRAC_W_MAX + 2;

    typedef struct packed {
        logic [STEP_W-1:0] acc_next;
        logic              cen;
        logic              cen_b;
    } step_t;

    // One accumulation: clamp num to den, add, wrap on den, flag the half-period crossing.
    function automatic step_t frac_step(input logic [STEP_W-1:0] acc,
                                        input logic [STEP_W-1:0] num,
                                        input logic [STEP_W-1:0] den);
        step_t             r;
        logic [STEP_W-1:0] n;
        logic [STEP_W-1:0] s;
        logic [STEP_W-1:0] h;
        r = '0;
        n = (num > den) ? den : num;
        s = acc + n;
        h = den >> 1;
        if (s >= den) begin
            r.acc_next = s - den;
            r.cen      = 1'b1;
        end else begin
            r.acc_next = s;
        end
        r.cen_b = (acc < h) && (s >= h) && (s < den);
        return r;
    endfunction

endpackage

// File: rtl/frac_cen_ch.sv
// One fractional enable channel: ratio registers, accumulator and registered strobes.
module frac_cen_ch
    import frac_cen_pkg::*;
#(
    parameter int unsigned FRAC_W = 16
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              pause,
    input  logic              load,
    input  logic [FRAC_W-1:0] cfg_num,
    input  logic [FRAC_W-1:0] cfg_den,
    output logic              cen,
    output logic              cen_b
);

    localparam int unsigned ACC_W = FRAC_W + 1;

    logic [FRAC_W-1:0] num;
    logic [FRAC_W-1:0] den;
    logic [ACC_W-1:0]  acc;
    step_t             step_c;
    logic              active_c;
    logic              unused_hi;

    always_comb begin
        step_c   = frac_step(STEP_W'(acc), STEP_W'(num), STEP_W'(den));
        active_c = run && !pause && (den != '0);
    end

    // acc stays below den, so the bits above ACC_W never carry information.
    assign unused_hi = ^step_c.acc_next[STEP_W-1:ACC_W];

    // A write takes effect next cycle; this cycle's strobe still comes from the old ratio.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            num   <= '0;
            den   <= '0;
            acc   <= '0;
            cen   <= 1'b0;
            cen_b <= 1'b0;
        end else begin
            if (load) begin
                num <= cfg_num;
                den <= cfg_den;
            end
            if (!run || load) begin
                acc <= '0;
            end else if (active_c) begin
                acc <= step_c.acc_next[ACC_W-1:0];
            end
            cen   <= active_c && step_c.cen;
            cen_b <= active_c && step_c.cen_b;
        end
    end

endmodule

// File: rtl/frac_cen_gen.sv
// Multi-channel fractional clock-enable generator gated by a PLL lock supervisor.
module frac_cen_gen
    import frac_cen_pkg::*;
#(
    parameter  int unsigned CHANNELS    = 4,
    parameter  int unsigned FRAC_W      = 16,
    parameter  int unsigned LOCK_CYCLES = 1024,
    localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                pll_lock,
    input  logic                pause,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [FRAC_W-1:0]   cfg_num,
    input  logic [FRAC_W-1:0]   cfg_den,
    output logic                ready,
    output logic [CHANNELS-1:0] cen,
    output logic [CHANNELS-1:0] cen_b
);

    localparam int unsigned     CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    lock_state_e      state;
    lock_state_e      state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             run_c;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ready <= (state_n == RUN);
        end
    end

    // Lock loss overrides every state and restarts the settle count.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (pll_lock) begin
                    state_n = SETTLE;
                    cnt_n   = '0;
                end
            end
            SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RUN:     state_n = RUN;
            default: state_n = WAIT_LOCK;
        endcase
        if (!pll_lock) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
        end
    end

    assign run_c = (state == RUN) && pll_lock;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic load;
        // Indices at or above CHANNELS never match, so such writes are dropped.
        assign load = cfg_we && (cfg_ch == CH_W'(c));

        frac_cen_ch #(
            .FRAC_W (FRAC_W)
        ) u_ch (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .run     (run_c),
            .pause   (pause),
            .load    (load),
            .cfg_num (cfg_num),
            .cfg_den (cfg_den),
            .cen     (cen[c]),
            .cen_b   (cen_b[c])
        );
    end

endmodule

// File: tb/tb_frac_cen_gen.sv
// Randomised and directed bench for frac_cen_gen against a count-based behavioural model.
module tb_frac_cen_gen;

    localparam int unsigned CH = 4;
    localparam int unsigned FW = 16;
    localparam int unsigned LC = 16;

    logic          refclk   = 1'b0;
    logic          rst_n    = 1'b0;
    logic          pll_lock = 1'b0;
    logic          pause    = 1'b0;
    logic          cfg_we   = 1'b0;
    logic [1:0]    cfg_ch   = '0;
    logic [FW-1:0] cfg_num  = '0;
    logic [FW-1:0] cfg_den  = '0;
    logic          ready;
    logic [CH-1:0] cen;
    logic [CH-1:0] cen_b;

    frac_cen_gen #(
        .CHANNELS    (CH),
        .FRAC_W      (FW),
        .LOCK_CYCLES (LC)
    ) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .pause    (pause),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_num  (cfg_num),
        .cfg_den  (cfg_den),
        .ready    (ready),
        .cen      (cen),
        .cen_b    (cen_b)
    );

    always #5 refclk = ~refclk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    bit check_en   = 1'b0;

    always @(posedge refclk) cyc <= cyc + 1;

    // Model: k = active steps since the last clear; strobes come from integer crossings of k*n.
    longint        k    [CH];
    logic [FW-1:0] mnum [CH];
    logic [FW-1:0] mden [CH];
    int            consec;
    logic          m_ready;
    logic [CH-1:0] m_cen;
    logic [CH-1:0] m_cenb;

    initial forever begin
        @(posedge refclk or negedge rst_n);
        if (!rst_n) begin
            consec  = 0;
            m_ready = 1'b0;
            m_cen   = '0;
            m_cenb  = '0;
            for (int c = 0; c < CH; c++) begin
                k[c] = 0; mnum[c] = '0; mden[c] = '0;
            end
        end else begin
            bit     run;
            bit     ld;
            longint n, d, h, a, b;
            run = m_ready && pll_lock;
            for (int c = 0; c < CH; c++) begin
                d  = longint'(mden[c]);
                n  = (mnum[c] > mden[c]) ? d : longint'(mnum[c]);
                ld = cfg_we && (int'(cfg_ch) == c);
                if (run && !pause && d != 0) begin
                    k[c]      = k[c] + 1;
                    a         = (k[c] - 1) * n;
                    b         = k[c] * n;
                    h         = d / 2;
                    m_cen[c]  = (b / d) != (a / d);
                    m_cenb[c] = !m_cen[c] && (((b + d - h) / d) != ((a + d - h) / d));
                end else begin
                    m_cen[c]  = 1'b0;
                    m_cenb[c] = 1'b0;
                end
                if (!run || ld) k[c] = 0;
                if (ld) begin
                    mnum[c] = cfg_num;
                    mden[c] = cfg_den;
                end
            end
            consec  = pll_lock ? ((consec < 1000) ? consec + 1 : consec) : 0;
            m_ready = (consec >= int'(LC) + 1);
        end
    end

    initial forever begin
        @(negedge refclk);
        if (check_en) begin
            vectors++;
            if ({ready, cen, cen_b} !== {m_ready, m_cen, m_cenb}) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: ready/cen/cen_b got %b/%b/%b expected %b/%b/%b",
                         cyc, ready, cen, cen_b, m_ready, m_cen, m_cenb);
            end
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge refclk);
        #1;
    endtask

    task automatic write_cfg(input int ch, input int num, input int den);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_num = 16'(num);
        cfg_den = 16'(den);
        cycle();
        cfg_we  = 1'b0;
    endtask

    task automatic wait_cen(input int ch, input int limit, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge refclk);
            if (cen[ch]) begin
                at = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready(input int limit, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge refclk);
            if (ready) begin
                at = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t_ready, t_d, ca, cb, at, early, bad, n1, n2, b2;
        bit ok;
        int first [CH];
        int second[CH];
        int fb0, sb0;

        repeat (3) cycle();
        check_en = 1'b1;
        check("reset_ready", longint'(ready), 0);
        check("reset_cen", longint'(cen), 0);
        check("reset_cen_b", longint'(cen_b), 0);
        rst_n = 1'b1;
        cycle();
        write_cfg(0, 1, 12);
        write_cfg(1, 2, 5);
        write_cfg(2, 7, 3);
        write_cfg(3, 1, 8);

        // Lock rises: ready exactly LC cycles after the sampling edge, no strobes before.
        pll_lock = 1'b1;
        t0 = cyc;
        early = 0;
        t_ready = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge refclk);
            if (ready) begin
                t_ready = cyc; ok = 1'b1; break;
            end
            if (cen != '0) early++;
        end
        check("lock_timeout", longint'(ok), 1);
        check("ready_latency", longint'(t_ready - (t0 + 1)), 16);
        check("cen_before_ready", longint'(early), 0);

        for (int c = 0; c < CH; c++) begin first[c] = 0; second[c] = 0; end
        fb0 = 0; sb0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge refclk);
            for (int c = 0; c < CH; c++) begin
                if (cen[c]) begin
                    if (first[c] == 0) first[c] = cyc - t_ready;
                    else if (second[c] == 0) second[c] = cyc - t_ready;
                end
            end
            if (cen_b[0]) begin
                if (fb0 == 0) fb0 = cyc - t_ready;
                else if (sb0 == 0) sb0 = cyc - t_ready;
            end
        end
        check("ch0_first_cen", longint'(first[0]), 12);
        check("ch0_second_cen", longint'(second[0]), 24);
        check("ch0_first_cen_b", longint'(fb0), 6);
        check("ch0_second_cen_b", longint'(sb0), 18);
        check("ch1_first_cen", longint'(first[1]), 3);
        check("ch1_second_cen", longint'(second[1]), 5);
        check("ch2_first_cen", longint'(first[2]), 1);
        check("ch2_second_cen", longint'(second[2]), 2);
        check("ch3_first_cen", longint'(first[3]), 8);

        n1 = 0; n2 = 0; b2 = 0;
        repeat (10000) begin
            @(negedge refclk);
            if (cen[1]) n1++;
            if (cen[2]) n2++;
            if (cen_b[2]) b2++;
        end
        check("ch1_cen_in_10000", longint'(n1), 4000);
        check("ch2_cen_in_10000", longint'(n2), 10000);
        check("ch2_cen_b_in_10000", longint'(b2), 0);
        cycle();

        // Five paused cycles three steps into a 1/8 period stretch it to 13.
        wait_cen(3, 20, ca, ok);
        check("ch3_pre_pause_timeout", longint'(ok), 1);
        repeat (3) @(posedge refclk);
        #1 pause = 1'b1;
        repeat (5) @(posedge refclk);
        #1 pause = 1'b0;
        wait_cen(3, 40, cb, ok);
        check("ch3_post_pause_timeout", longint'(ok), 1);
        check("ch3_paused_period", longint'(cb - ca), 13);
        cycle();

        // Disable ch2: the write cycle still uses 7/3, then silence.
        write_cfg(2, 7, 0);
        @(negedge refclk);
        check("ch2_old_ratio_in_write_cycle", longint'(cen[2]), 1);
        bad = 0;
        repeat (20) begin
            @(negedge refclk);
            if (cen[2]) bad++;
        end
        check("ch2_disabled_cen", longint'(bad), 0);
        cycle();

        // One-cycle lock drop in RUN: immediate silence, full re-settle, accumulators restart.
        pll_lock = 1'b0;
        cycle();
        t_d = cyc;
        pll_lock = 1'b1;
        @(negedge refclk);
        check("lock_drop_ready", longint'(ready), 0);
        check("lock_drop_cen", longint'(cen), 0);
        wait_ready(100, t_ready, ok);
        check("relock_timeout", longint'(ok), 1);
        check("relock_latency", longint'(t_ready - (t_d + 1)), 16);
        wait_cen(0, 40, at, ok);
        check("relock_ch0_timeout", longint'(ok), 1);
        check("relock_ch0_first_cen", longint'(at - t_ready), 12);
        cycle();

        repeat (4000) begin
            pll_lock = ($urandom_range(0, 199) != 0);
            pause    = ($urandom_range(0, 15) == 0);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                cfg_num = 16'($urandom);
                cfg_den = 16'($urandom);
            end else begin
                cfg_num = 16'($urandom_range(0, 20));
                cfg_den = 16'($urandom_range(0, 20));
            end
            cycle();
        end
        cfg_we   = 1'b0;
        pause    = 1'b0;
        pll_lock = 1'b1;
        cycle();

        // Asynchronous reset mid-run clears outputs and the ratio registers.
        write_cfg(0, 1, 1);
        wait_ready(100, at, ok);
        check("pre_reset_ready_timeout", longint'(ok), 1);
        @(negedge refclk);
        check("pre_reset_cen0", longint'(cen[0]), 1);
        @(posedge refclk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_ready", longint'(ready), 0);
        check("async_reset_cen", longint'({cen, cen_b}), 0);
        @(posedge refclk);
        #1 rst_n = 1'b1;
        bad = 0;
        ok = 1'b0;
        repeat (60) begin
            @(negedge refclk);
            if (cen != '0 || cen_b != '0) bad++;
            if (ready) ok = 1'b1;
        end
        check("post_reset_ready", longint'(ok), 1);
        check("post_reset_no_strobes", longint'(bad), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
